// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master write engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_scl_tick_gen.sv
// Quarter-period divider and 2-bit phase counter for the SCL timebase.
// stall_i freezes the divider (used by the clock-stretch build).
module i2c_scl_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic       stall_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [1:0]    phase_q;

  assign tick_o  = en_i && !stall_i
                && (div_q == DW'(CLK_DIV - 1));
  assign phase_o = phase_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q   <= '0;
      phase_q <= '0;
    end else if (!en_i) begin
      div_q   <= '0;
      phase_q <= '0;
    end else if (!stall_i) begin
      if (tick_o) begin
        div_q   <= '0;
        phase_q <= phase_q + 2'd1;
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_tx_engine.sv
// I2C master write engine draining a show-ahead byte FIFO.
// Optional: define I2C_CLOCK_STRETCH_EN to add scl_i clock stretching.
module i2c_master_tx_engine
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [6:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_read_inc_o,
  input  logic                  sda_i,
`ifdef I2C_CLOCK_STRETCH_EN
  input  logic                  scl_i,
`endif
  output logic                  sda_o,
  output logic                  scl_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  nack_o
);

  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  state_e                state_q;
  logic [6:0]            addr_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bitcnt_q;
  logic                  ack_q;
  logic                  scl_q;
  logic                  sda_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  nack_q;
  logic                  pop_q;

  logic       tick;
  logic [1:0] phase;
  logic       stall;
  logic       step_end;

`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = (state_q == BIT || state_q == ACK)
              && phase == PH_2 && scl_q && !scl_i;
`else
  assign stall = 1'b0;
`endif

  i2c_scl_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .en_i      (state_q != IDLE),
    .stall_i   (stall),
    .tick_o    (tick),
    .phase_o   (phase)
  );

  assign step_end = tick && (phase == PH_3);

  assign scl_o           = scl_q;
  assign sda_o           = sda_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign nack_o          = nack_q;
  assign fifo_read_inc_o = pop_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      ack_q    <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      pop_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pop_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (start_i) begin
            addr_q  <= addr_i;
            nack_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          scl_q <= 1'b1;
          sda_q <= !phase[1];
          if (step_end) begin
            shift_q  <= DATA_WIDTH'({addr_q, RW_WRITE})
                        << (DATA_WIDTH - 8);
            bitcnt_q <= '0;
            state_q  <= BIT;
          end
        end
        BIT: begin
          scl_q <= phase[1];
          sda_q <= shift_q[DATA_WIDTH-1];
          if (step_end) begin
            shift_q  <= shift_q << 1;
            bitcnt_q <= bitcnt_q + BW'(1);
            if (bitcnt_q == BW'(DATA_WIDTH - 1)) begin
              bitcnt_q <= '0;
              state_q  <= ACK;
            end
          end
        end
        ACK: begin
          scl_q <= phase[1];
          sda_q <= 1'b1;
          if (tick && phase == PH_2) begin
            ack_q <= sda_i;
            if (sda_i) nack_q <= 1'b1;
          end
          // FIFO emptiness is only looked at here, so late refills count
          if (step_end) begin
            if (ack_q || fifo_empty_i) begin
              state_q <= STOP;
            end else begin
              shift_q <= fifo_data_i;
              pop_q   <= 1'b1;
              state_q <= BIT;
            end
          end
        end
        STOP: begin
          scl_q <= (phase != PH_0);
          sda_q <= phase[1];
          if (step_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_master_tx_engine.md
Name: i2c_master_tx_engine

Overview:
Single-clock I2C master write engine that sits on the read side of the byte FIFO and consumes its output. On a start request it issues START, sends a 7-bit address with R/W=0, then pops FIFO bytes and serialises them MSB-first until the FIFO is empty, a NACK is received, or STOP is reached. SCL and SDA are open-drain style outputs: 0 drives the line low, 1 releases it.

Parameters:
DATA_WIDTH, 8, byte width; must equal the FIFO data width.
CLK_DIV, 4, system clocks per SCL quarter-period (min 2). One bit time = 4*CLK_DIV clocks.

Ports:
clock_i  input  1  system clock
reset_n_i  input  1  asynchronous active-low reset
start_i  input  1  single-cycle request to begin a transaction
addr_i  input  7  slave address, sampled when start_i is accepted
fifo_data_i  input  DATA_WIDTH  FIFO head word, valid while fifo_empty_i=0
fifo_empty_i  input  1  FIFO empty flag
fifo_read_inc_o  output  1  one-cycle pop strobe to the FIFO read side
sda_i  input  1  sampled SDA line
sda_o  output  1  SDA drive: 0 = pull low, 1 = release
scl_o  output  1  SCL drive: 0 = pull low, 1 = release
busy_o  output  1  transaction in progress
done_o  output  1  one-cycle pulse when returning to IDLE
nack_o  output  1  sticky; set on any NACK, cleared on accepted start_i

Behaviour:
- Interface decision: one clock (clock_i); reset is asynchronous and active-low (reset_n_i).
- Reset (asynchronous, any state): state=IDLE, scl_o=1, sda_o=1, busy_o=0, done_o=0, nack_o=0, fifo_read_inc_o=0, and all counters are cleared.
- Timing: a divider counter 0..CLK_DIV-1 generates the quarter tick. A 2-bit phase counter advances on each tick, and each state step spans phases 0-3.
- IDLE: start_i=1 is accepted, which latches addr_i, clears nack_o, sets busy_o and moves to START. start_i is ignored while busy_o=1.
- START: SCL=1 throughout. SDA=1 in phases 0-1 and SDA=0 in phases 2-3. Then load the shift register with {addr,1'b0} and go to BIT.
- BIT: phases 0-1 hold SCL=0 with SDA set to the shift MSB at phase 0. Phases 2-3 hold SCL=1. The shift register shifts after phase 3. After 8 bits, go to ACK.
- ACK: SDA is released. SCL=0 in phases 0-1 and SCL=1 in phases 2-3. sda_i is sampled on the last clock of phase 2.
  - sda_i=1 (NACK): nack_o is set and the engine goes to STOP without popping.
  - sda_i=0 with fifo_empty_i=1 at the end of phase 3: go to STOP.
  - sda_i=0 with fifo_empty_i=0: load fifo_data_i into the shift register, pulse fifo_read_inc_o for exactly one cycle in that same clock, and go to BIT.
- Head word: the FIFO presents it combinationally (show-ahead), and the pop takes effect at the next clock edge.
- STOP sequence: phase 0 SCL=0, SDA=0; phase 1 SCL=1, SDA=0; phases 2-3 SCL=1, SDA=1. Then go to IDLE with done_o=1 for one cycle and busy_o=0.
- Empty FIFO at start: an address-only probe is sent (START, addr, ACK, STOP) with no pops.
- FIFO refilled mid-transaction: the empty flag is evaluated only at the end of ACK.
- Outputs are registered, so there are no combinational paths from inputs to scl_o or sda_o.

Optional Feature:
I2C_CLOCK_STRETCH_EN: adds input scl_i (1 bit). When it is defined, the divider stalls in phase 2 of BIT and ACK while scl_o=1 and scl_i=0, so a slave can stretch the clock. Without it, scl_i does not exist and timing is strictly periodic.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding localparams: IDLE, START, BIT, ACK, STOP;
  - the phase indices;
  - the R/W bit constants.
- One sub-module, i2c_scl_tick_gen, holds the divider and phase counter. It outputs tick and phase, and takes a stall input used under the macro.

Test Plan:
- Reset: after reset_n_i is asserted, scl_o=1, sda_o=1, busy_o=0, done_o=0, nack_o=0, and fifo_read_inc_o=0, including when reset is applied mid-byte.
- Normal write: CLK_DIV=4, FIFO holds 0xA5 then 0x3C, addr_i=0x50, slave ACKs. Expect:
  - SDA bytes 0xA0, 0xA5, 0x3C are seen at SCL rising edges;
  - exactly 2 fifo_read_inc_o pulses;
  - done_o occurs 464 clocks after START begins.
- Address-only probe: empty FIFO, start_i, addr 0x12. Expect byte 0x24, STOP, done_o, and zero pops.
- NACK on address: sda_i=1 during ACK, FIFO holds 0x11. Expect nack_o=1, STOP, no pop, and the FIFO still holds 0x11. A new start_i clears nack_o.
- Mid-transaction reset: assert reset_n_i during bit 4 of data. Expect immediate scl_o=1, sda_o=1, state IDLE, and no further pops.
- I2C_CLOCK_STRETCH_EN: hold scl_i=0 for 20 clocks during a data bit. Expect the SCL high phase to be extended by 20 clocks and the data to remain correct.
